// File: rtl/display_pkg.sv
// Shared definitions for the LED matrix scan path: panel geometry,
// screen-code bit layout and the scan state encoding.
package display_pkg;

    localparam int PANEL_COLS       = 32;
    localparam int PANEL_ROW_ADDRS  = 8;
    localparam int SCREEN_COLOR_BIT = 5;

    typedef enum logic [1:0] {
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_SHOW
    } scan_state_t;

endpackage

// File: rtl/bar_pixel.sv
// Bar-graph pixel rule: a column is lit when it lies left of the bar length;
// the colour bit selects red or green, blue is never used.
module bar_pixel
    import display_pkg::*;
#(
    parameter int COL_W = 5
)(
    input  logic [5:0]       screen_q,
    input  logic [COL_W-1:0] col,
    output logic             r,
    output logic             g,
    output logic             b
);

    logic lit;

    always_comb begin
        lit = 32'(col) < 32'(screen_q[4:0]);
        r   = lit &  screen_q[SCREEN_COLOR_BIT];
        g   = lit & ~screen_q[SCREEN_COLOR_BIT];
        b   = 1'b0;
    end

endmodule

// File: rtl/hub75_bar_driver.sv
// HUB75 1:8 scan driver rendering the 6-bit screen code as a horizontal bar.
// Shifts one row, blanks, latches, then dwells with the row displayed.
module hub75_bar_driver
    import display_pkg::*;
#(
    parameter int COLS      = PANEL_COLS,
    parameter int ROW_ADDRS = PANEL_ROW_ADDRS,
    parameter int CLK_DIV   = 2,
    parameter int ON_CYCLES = 256
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] screen,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       OCLK,
    output logic       LAT,
    output logic       OEN,
    output logic       frame_done
);

    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROW_ADDRS > 1) ? $clog2(ROW_ADDRS) : 1;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int DWELL_W = $clog2(ON_CYCLES + 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_ADDRS - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ON_CYCLES - 1);

    scan_state_t        state;
    logic [5:0]         screen_q;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [DIV_W-1:0]   div_cnt;
    logic               phase;
    logic [DWELL_W-1:0] dwell;
    logic               shown;

    logic               sample_now;
    logic [5:0]         pix_screen;
    logic               pix_r;
    logic               pix_g;
    logic               pix_b;

    // The first shift cycle of row 0 both captures screen and emits column 0,
    // so the pixel for that cycle is evaluated from the value being captured.
    always_comb begin
        sample_now = (state == S_SHIFT) && (row == '0) && (col == '0) &&
                     (div_cnt == '0) && !phase;
        pix_screen = sample_now ? screen : screen_q;
    end

    bar_pixel #(
        .COL_W (COL_W)
    ) u_bar_pixel (
        .screen_q (pix_screen),
        .col      (col),
        .r        (pix_r),
        .g        (pix_g),
        .b        (pix_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_SHIFT;
            screen_q   <= '0;
            row        <= '0;
            col        <= '0;
            div_cnt    <= '0;
            phase      <= 1'b0;
            dwell      <= '0;
            shown      <= 1'b0;
            r1         <= 1'b0;
            g1         <= 1'b0;
            b1         <= 1'b0;
            r2         <= 1'b0;
            g2         <= 1'b0;
            b2         <= 1'b0;
            {C, B, A}  <= '0;
            OCLK       <= 1'b0;
            LAT        <= 1'b0;
            OEN        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            LAT        <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                S_SHIFT: begin
                    if (sample_now) begin
                        screen_q <= screen;
                    end
                    // Dark until the first row has been shown, then the
                    // previous row stays lit while the next one shifts in.
                    OEN          <= ~shown;
                    OCLK         <= phase;
                    {r1, g1, b1} <= {pix_r, pix_g, pix_b};
                    {r2, g2, b2} <= {pix_r, pix_g, pix_b};
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            if (col == COL_LAST) begin
                                col   <= '0;
                                state <= S_BLANK;
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_BLANK: begin
                    OEN       <= 1'b1;
                    OCLK      <= 1'b0;
                    {C, B, A} <= 3'(row);
                    state     <= S_LATCH;
                end
                S_LATCH: begin
                    OEN        <= 1'b1;
                    LAT        <= 1'b1;
                    frame_done <= (row == ROW_LAST);
                    dwell      <= '0;
                    state      <= S_SHOW;
                end
                S_SHOW: begin
                    OEN   <= 1'b0;
                    shown <= 1'b1;
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        row   <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                        state <= S_SHIFT;
                    end else begin
                        dwell <= dwell + DWELL_W'(1);
                    end
                end
                default: state <= S_SHIFT;
            endcase
        end
    end

endmodule
